// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared state encoding and sizing for the round-robin arbiter
package rr_arbiter4_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

endpackage

// File: rtl/decoder2x4.sv
// rtl/decoder2x4.sv - binary 2-bit index to 4-bit one-hot decode
module decoder2x4 (
  input  logic [1:0] sel_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = 4'b0000;
    onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-requester round-robin arbiter with bounded hold and dead gap
module rr_arbiter4
  import rr_arbiter4_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            rel,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      grant_id,
  output logic            grant_valid,
  output logic            timeout
);

  localparam int HW = $clog2(MAX_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  arb_state_e      state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [NREQ-1:0] grant_q;
  logic            grant_valid_q;
  logic            timeout_q, timeout_d;

  logic            found;
  logic [1:0]      pick;
  logic [1:0]      idx;
  logic [NREQ-1:0] dec_onehot;

  // Search starts just above the last owner so it lands at the bottom of the order.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = ptr_q;
    for (int k = 1; k <= NREQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_id_d = grant_id_q;
    hold_d     = hold_q;
    timeout_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          state_d    = ST_GRANT;
          grant_id_d = pick;
          ptr_d      = pick;
          hold_d     = '0;
        end
      end
      ST_GRANT: begin
        // A release wins over an expiring hold, so timeout only flags real overruns.
        if (rel || !req[grant_id_q]) begin
          state_d = ST_GAP;
        end else if (hold_q == HOLD_LAST) begin
          state_d   = ST_GAP;
          timeout_d = 1'b1;
        end else begin
          hold_d = hold_q + HW'(1);
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  decoder2x4 u_dec (
    .sel_i    (grant_id_d),
    .onehot_o (dec_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      ptr_q         <= 2'd3;
      grant_id_q    <= 2'd0;
      hold_q        <= '0;
      grant_q       <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      grant_id_q    <= grant_id_d;
      hold_q        <= hold_d;
      grant_q       <= dec_onehot & {NREQ{state_d == ST_GRANT}};
      grant_valid_q <= (state_d == ST_GRANT);
      timeout_q     <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = grant_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed vector bench for rr_arbiter4
module tb_rr_arbiter4;

  typedef struct {
    logic [3:0] req;
    logic       rel;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
    logic       to;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       rel;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  int   n_vec = 0;
  int   n_bad = 0;
  vec_t vecs[$];

  rr_arbiter4 #(.MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .rel         (rel),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic add(input logic [3:0] r, input logic l, input logic [3:0] g,
                     input logic [1:0] id, input logic v, input logic to);
    vec_t e;
    e.req = r; e.rel = l; e.g = g; e.id = id; e.v = v; e.to = to;
    vecs.push_back(e);
  endtask

  task automatic check(input string name, input logic [3:0] g, input logic [1:0] id,
                       input logic v, input logic to);
    n_vec++;
    if (grant !== g || grant_id !== id || grant_valid !== v || timeout !== to) begin
      n_bad++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b timeout=%b, expected grant=%b id=%0d valid=%b timeout=%b",
               name, grant, grant_id, grant_valid, timeout, g, id, v, to);
    end
  endtask

  task automatic step(input logic [3:0] r, input logic l);
    req = r;
    rel = l;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    rel   = 1'b0;

    // Round robin over all four with rel after two grant cycles each.
    add(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b1111, 0, 4'b0000, 2'd0, 0, 0);
    for (int o = 1; o < 4; o++) begin
      add(4'b1111, 0, 4'(1 << o), 2'(o), 1, 0);
      add(4'b1111, 0, 4'(1 << o), 2'(o), 1, 0);
      add(4'b1111, 1, 4'b0000, 2'(o), 0, 0);
      add(4'b1111, 0, 4'b0000, 2'(o), 0, 0);
    end
    add(4'b1111, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b1111, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);
    // Hold limit: eight grant cycles, timeout in the gap, then re-grant.
    for (int i = 0; i < 8; i++) add(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(4'b0100, 0, 4'b0000, 2'd2, 0, 1);
    add(4'b0100, 0, 4'b0000, 2'd2, 0, 0);
    add(4'b0100, 0, 4'b0100, 2'd2, 1, 0);
    add(4'b0000, 0, 4'b0000, 2'd2, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd2, 0, 0);
    // Owner 1 drops its request; requester 3 wins the next search.
    add(4'b0010, 0, 4'b0010, 2'd1, 1, 0);
    add(4'b1010, 0, 4'b0010, 2'd1, 1, 0);
    add(4'b1000, 0, 4'b0000, 2'd1, 0, 0);
    add(4'b1010, 0, 4'b0000, 2'd1, 0, 0);
    add(4'b1010, 0, 4'b1000, 2'd3, 1, 0);
    add(4'b1010, 1, 4'b0000, 2'd3, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd3, 0, 0);
    // rel coincides with the last allowed hold cycle.
    for (int i = 0; i < 8; i++) add(4'b0001, 0, 4'b0001, 2'd0, 1, 0);
    add(4'b0001, 1, 4'b0000, 2'd0, 0, 0);
    add(4'b0000, 0, 4'b0000, 2'd0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 4'b0000, 2'd0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++) begin
      step(4'b0000, 1'b1);
      check("rel_in_idle", 4'b0000, 2'd0, 0, 0);
    end
    step(4'b0000, 1'b0);
    check("idle_quiet", 4'b0000, 2'd0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].req, vecs[i].rel);
      check($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].v, vecs[i].to);
    end

    step(4'b0010, 1'b0);
    check("pre_reset_grant", 4'b0010, 2'd1, 1, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 2'd0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(4'b0011, 1'b0);
    check("post_reset_first", 4'b0001, 2'd0, 1, 0);
    step(4'b0011, 1'b1);
    check("post_reset_rel", 4'b0000, 2'd0, 0, 0);
    step(4'b0011, 1'b0);
    step(4'b0011, 1'b0);
    check("post_reset_next", 4'b0010, 2'd1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
